// File: rtl/mcpu_pkg.sv
// Shared types and constants for the mcpu core: opcode encodings, field widths
// and the two-state instruction sequencer.
package mcpu_pkg;

  localparam int unsigned OPERAND_SIZE = 4;
  localparam int unsigned WORD_SIZE    = 16;
  localparam int unsigned PC_W         = 8;

  localparam logic [OPERAND_SIZE-1:0] OP_NOP          = 4'd0;
  localparam logic [OPERAND_SIZE-1:0] OP_AND          = 4'd1;
  localparam logic [OPERAND_SIZE-1:0] OP_OR           = 4'd2;
  localparam logic [OPERAND_SIZE-1:0] OP_XOR          = 4'd3;
  localparam logic [OPERAND_SIZE-1:0] OP_NOT          = 4'd4;
  localparam logic [OPERAND_SIZE-1:0] OP_ADD          = 4'd5;
  localparam logic [OPERAND_SIZE-1:0] OP_SUB          = 4'd6;
  localparam logic [OPERAND_SIZE-1:0] OP_LSL          = 4'd7;
  localparam logic [OPERAND_SIZE-1:0] OP_LSR          = 4'd8;
  localparam logic [OPERAND_SIZE-1:0] OP_SHORT_TO_REG = 4'd9;
  localparam logic [OPERAND_SIZE-1:0] OP_BNZ          = 4'd10;
  localparam logic [OPERAND_SIZE-1:0] OP_BZ           = 4'd11;

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } state_t;

endpackage

// File: rtl/mcpu_ram.sv
// Unified instruction/data memory: combinational read, synchronous write.
module mcpu_ram
  import mcpu_pkg::*;
#(
  parameter int unsigned RAM_SIZE = 256
) (
  input  logic                 clk,
  input  logic [PC_W-1:0]      i_addr,
  output logic [WORD_SIZE-1:0] o_rdata,
  input  logic                 i_we,
  input  logic [PC_W-1:0]      i_waddr,
  input  logic [WORD_SIZE-1:0] i_wdata
);

  logic [WORD_SIZE-1:0] mem [0:RAM_SIZE-1];

  assign o_rdata = mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/mcpu_regfile.sv
// General-purpose register file: two combinational read ports, one synchronous
// write port. Contents are deliberately not reset.
module mcpu_regfile
  import mcpu_pkg::*;
#(
  parameter int unsigned REGISTERS_NUMBER = 16
) (
  input  logic                    clk,
  input  logic [OPERAND_SIZE-1:0] i_raddr_a,
  output logic [WORD_SIZE-1:0]    o_rdata_a,
  input  logic [OPERAND_SIZE-1:0] i_raddr_b,
  output logic [WORD_SIZE-1:0]    o_rdata_b,
  input  logic                    i_we,
  input  logic [OPERAND_SIZE-1:0] i_waddr,
  input  logic [WORD_SIZE-1:0]    i_wdata
);

  logic [WORD_SIZE-1:0] R [0:REGISTERS_NUMBER-1];

  assign o_rdata_a = R[i_raddr_a];
  assign o_rdata_b = R[i_raddr_b];

  always_ff @(posedge clk) begin
    if (i_we) begin
      R[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/mcpu.sv
// mcpu core: two-cycle FETCH/EXECUTE sequencer with inline ALU.
// Define MCPU_TRACE_EN to print a per-instruction execution trace in simulation.
module mcpu
  import mcpu_pkg::*;
(
  input logic clk,
  input logic reset
);

  // Opcodes re-exported so benches can refer to cpuinst.OP_*.
  localparam logic [OPERAND_SIZE-1:0] OP_NOP          = mcpu_pkg::OP_NOP;
  localparam logic [OPERAND_SIZE-1:0] OP_AND          = mcpu_pkg::OP_AND;
  localparam logic [OPERAND_SIZE-1:0] OP_OR           = mcpu_pkg::OP_OR;
  localparam logic [OPERAND_SIZE-1:0] OP_XOR          = mcpu_pkg::OP_XOR;
  localparam logic [OPERAND_SIZE-1:0] OP_NOT          = mcpu_pkg::OP_NOT;
  localparam logic [OPERAND_SIZE-1:0] OP_ADD          = mcpu_pkg::OP_ADD;
  localparam logic [OPERAND_SIZE-1:0] OP_SUB          = mcpu_pkg::OP_SUB;
  localparam logic [OPERAND_SIZE-1:0] OP_LSL          = mcpu_pkg::OP_LSL;
  localparam logic [OPERAND_SIZE-1:0] OP_LSR          = mcpu_pkg::OP_LSR;
  localparam logic [OPERAND_SIZE-1:0] OP_SHORT_TO_REG = mcpu_pkg::OP_SHORT_TO_REG;
  localparam logic [OPERAND_SIZE-1:0] OP_BNZ          = mcpu_pkg::OP_BNZ;
  localparam logic [OPERAND_SIZE-1:0] OP_BZ           = mcpu_pkg::OP_BZ;

  state_t                  r_state, w_state_next;
  logic [PC_W-1:0]         r_pc, w_pc_next;
  logic [WORD_SIZE-1:0]    r_ir, w_ir_next;
  logic [WORD_SIZE-1:0]    w_instr;
  logic [OPERAND_SIZE-1:0] w_op, w_dst, w_src_a, w_src_b, w_rb_addr;
  logic [7:0]              w_imm;
  logic [WORD_SIZE-1:0]    w_a, w_b, w_wdata;
  logic                    w_we, w_wr_en, w_is_branch, w_taken;

  assign w_op        = r_ir[15:12];
  assign w_dst       = r_ir[11:8];
  assign w_src_a     = r_ir[7:4];
  assign w_src_b     = r_ir[3:0];
  assign w_imm       = r_ir[7:0];
  assign w_is_branch = (w_op == OP_BNZ) || (w_op == OP_BZ);
  // Branches test the register named in the dst field via read port B.
  assign w_rb_addr   = w_is_branch ? w_dst : w_src_b;
  // A reset landing on EXECUTE aborts the instruction before writeback.
  assign w_wr_en     = w_we && !reset;

  mcpu_ram #(.RAM_SIZE(256)) raminst (
    .clk     (clk),
    .i_addr  (r_pc),
    .o_rdata (w_instr),
    .i_we    (1'b0),
    .i_waddr ('0),
    .i_wdata ('0)
  );

  mcpu_regfile #(.REGISTERS_NUMBER(16)) regfileinst (
    .clk       (clk),
    .i_raddr_a (w_src_a),
    .o_rdata_a (w_a),
    .i_raddr_b (w_rb_addr),
    .o_rdata_b (w_b),
    .i_we      (w_wr_en),
    .i_waddr   (w_dst),
    .i_wdata   (w_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
    end
  end

  // Sequencer, decode and ALU.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_we         = 1'b0;
    w_wdata      = '0;
    w_taken      = 1'b0;
    case (r_state)
      FETCH: begin
        w_ir_next    = w_instr;
        w_pc_next    = r_pc + PC_W'(1);
        w_state_next = EXECUTE;
      end
      EXECUTE: begin
        w_state_next = FETCH;
        case (w_op)
          OP_AND:          begin w_we = 1'b1; w_wdata = w_a & w_b; end
          OP_OR:           begin w_we = 1'b1; w_wdata = w_a | w_b; end
          OP_XOR:          begin w_we = 1'b1; w_wdata = w_a ^ w_b; end
          OP_NOT:          begin w_we = 1'b1; w_wdata = ~w_a; end
          OP_ADD:          begin w_we = 1'b1; w_wdata = w_a + w_b; end
          OP_SUB:          begin w_we = 1'b1; w_wdata = w_a - w_b; end
          OP_LSL:          begin w_we = 1'b1; w_wdata = w_a << w_b; end
          OP_LSR:          begin w_we = 1'b1; w_wdata = w_a >> w_b; end
          OP_SHORT_TO_REG: begin w_we = 1'b1; w_wdata = WORD_SIZE'(w_imm); end
          OP_BNZ:          w_taken = (w_b != '0);
          OP_BZ:           w_taken = (w_b == '0);
          default:         w_we = 1'b0;
        endcase
        if (w_taken) begin
          w_pc_next = w_imm;
        end
      end
    endcase
  end

`ifdef MCPU_TRACE_EN
  always @(posedge clk) begin
    if (!reset && r_state == EXECUTE) begin
      if (w_is_branch)
        $display("mcpu trace: pc=%0d op=%0d branch %s", r_pc - PC_W'(1), w_op,
                 w_taken ? "taken" : "not taken");
      else if (w_we)
        $display("mcpu trace: pc=%0d op=%0d R%0d <= 0x%04h", r_pc - PC_W'(1), w_op,
                 w_dst, w_wdata);
      else
        $display("mcpu trace: pc=%0d op=%0d nop", r_pc - PC_W'(1), w_op);
    end
  end
`else
`endif

endmodule

// File: tb/tb_mcpu.sv
// Self-checking bench for mcpu: directed scenarios plus random programs checked
// against an instruction-level reference model.
module tb_mcpu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mcpu cpuinst (.clk(clk), .reset(reset));

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] m_mem [256];
  logic [15:0] m_r [16];
  int          m_pc;

  // Instruction-set reference model: executes n whole instructions.
  task automatic model_run(input int n);
    logic [15:0] ir, av, bv, res;
    logic [3:0]  op, d;
    bit          wr;
    for (int k = 0; k < n; k++) begin
      ir   = m_mem[m_pc];
      m_pc = (m_pc + 1) % 256;
      op   = ir[15:12];
      d    = ir[11:8];
      av   = m_r[ir[7:4]];
      bv   = m_r[ir[3:0]];
      wr   = 1'b1;
      res  = 16'h0;
      case (op)
        4'd1: res = av & bv;
        4'd2: res = av | bv;
        4'd3: res = av ^ bv;
        4'd4: res = ~av;
        4'd5: res = 16'((int'(av) + int'(bv)) % 65536);
        4'd6: res = 16'((int'(av) - int'(bv) + 65536) % 65536);
        4'd7: res = (bv >= 16) ? 16'h0 : 16'((int'(av) * (1 << bv)) % 65536);
        4'd8: res = (bv >= 16) ? 16'h0 : 16'(int'(av) / (1 << bv));
        4'd9: res = {8'h00, ir[7:0]};
        4'd10: begin wr = 1'b0; if (m_r[d] != 0) m_pc = int'(ir[7:0]); end
        4'd11: begin wr = 1'b0; if (m_r[d] == 0) m_pc = int'(ir[7:0]); end
        default: wr = 1'b0;
      endcase
      if (wr) m_r[d] = res;
    end
  endtask

  // Asserts reset across one rising edge; leaves reset high at a falling edge.
  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) begin
      m_mem[a] = 16'h0;
      cpuinst.raminst.mem[a] = 16'h0;
    end
    m_pc = 0;
  endtask

  task automatic put(input int a, input logic [15:0] w);
    m_mem[a] = w;
    cpuinst.raminst.mem[a] = w;
  endtask

  task automatic setr(input int i, input logic [15:0] v);
    m_r[i] = v;
    cpuinst.regfileinst.R[i] = v;
  endtask

  // Releases reset at a falling edge and runs n instructions (2 cycles each).
  task automatic run(input int n);
    reset = 1'b0;
    repeat (2 * n) @(posedge clk);
    @(negedge clk);
    model_run(n);
  endtask

  task automatic test_reset();
    hold_reset();
    clear_mem();
    for (int i = 0; i < 16; i++) setr(i, 16'(i * 3 + 1));
    put(0, 16'h9008);
    put(1, 16'h9155);
    put(2, 16'h9266);
    run(3);
    @(negedge clk);
    reset = 1'b1;
    setr(0, 16'h1111);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (cpuinst.r_pc !== 8'd0) begin
      n_err++; $display("FAIL reset_pc: got %0d want 0", cpuinst.r_pc);
    end
    n_cmp++;
    if (cpuinst.r_ir !== 16'h0) begin
      n_err++; $display("FAIL reset_ir: got %h want 0000", cpuinst.r_ir);
    end
    n_cmp++;
    if (cpuinst.r_state !== mcpu_pkg::FETCH) begin
      n_err++; $display("FAIL reset_state: got %0d want FETCH", cpuinst.r_state);
    end
    n_cmp++;
    if (cpuinst.regfileinst.R[1] !== 16'h0055) begin
      n_err++; $display("FAIL reset_keeps_regs: got %h want 0055", cpuinst.regfileinst.R[1]);
    end
    m_pc = 0;
    run(1);
    n_cmp++;
    if (cpuinst.regfileinst.R[0] !== 16'd8) begin
      n_err++; $display("FAIL start_r0: got %h want 0008", cpuinst.regfileinst.R[0]);
    end
    n_cmp++;
    if (cpuinst.r_pc !== 8'd1) begin
      n_err++; $display("FAIL start_pc: got %0d want 1", cpuinst.r_pc);
    end
  endtask

  task automatic test_wide_const();
    hold_reset();
    clear_mem();
    setr(15, 16'hDEAD);
    setr(14, 16'hBEEF);
    put(0, 16'h9008);
    put(1, 16'h9F0A);
    put(2, 16'h7FF0);
    put(3, 16'h9E51);
    put(4, 16'h2FFE);
    run(5);
    n_cmp++;
    if (cpuinst.regfileinst.R[15] !== 16'h0A51) begin
      n_err++; $display("FAIL wide_const: got %h want 0a51", cpuinst.regfileinst.R[15]);
    end
  endtask

  task automatic test_bounds();
    logic [15:0] instr [6];
    logic [15:0] expv [6];
    instr = '{16'h7213, 16'h8214, 16'h5215, 16'h6265, 16'h7217, 16'h8217};
    expv  = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h8000, 16'h0001};
    for (int c = 0; c < 6; c++) begin
      hold_reset();
      clear_mem();
      setr(1, 16'hFFFF);
      setr(2, 16'hA5A5);
      setr(3, 16'd16);
      setr(4, 16'h0100);
      setr(5, 16'd1);
      setr(6, 16'd0);
      setr(7, 16'd15);
      put(0, instr[c]);
      run(1);
      n_cmp++;
      if (cpuinst.regfileinst.R[2] !== expv[c]) begin
        n_err++;
        $display("FAIL bounds_%0d: instr %h got %h want %h", c, instr[c],
                 cpuinst.regfileinst.R[2], expv[c]);
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] instr [3];
    logic [7:0]  exp_pc [3];
    instr  = '{16'hA914, 16'hB914, 16'hA106};
    exp_pc = '{8'd1, 8'd20, 8'd6};
    for (int c = 0; c < 3; c++) begin
      hold_reset();
      clear_mem();
      setr(9, 16'd0);
      setr(1, 16'd1);
      put(0, instr[c]);
      run(1);
      n_cmp++;
      if (cpuinst.r_pc !== exp_pc[c]) begin
        n_err++;
        $display("FAIL branch_%0d: instr %h pc got %0d want %0d", c, instr[c],
                 cpuinst.r_pc, exp_pc[c]);
      end
      n_cmp++;
      if (cpuinst.regfileinst.R[9] !== 16'd0 || cpuinst.regfileinst.R[1] !== 16'd1) begin
        n_err++;
        $display("FAIL branch_nowrite_%0d: R9 %h R1 %h want 0000 0001", c,
                 cpuinst.regfileinst.R[9], cpuinst.regfileinst.R[1]);
      end
    end
  endtask

  task automatic test_hailstone();
    logic [7:0] pc_now;
    hold_reset();
    clear_mem();
    put(0, 16'h9F1B);
    put(1, 16'h9101);
    put(2, 16'h9008);
    put(3, 16'h9900);
    put(6, 16'h32F1);
    put(7, 16'hA209);
    put(8, 16'hB907);
    put(9, 16'h13F1);
    put(10, 16'hA314);
    put(11, 16'h8FF1);
    put(12, 16'hB906);
    put(20, 16'h54FF);
    put(21, 16'h5F4F);
    put(22, 16'h5FF1);
    put(23, 16'hB906);
    run(1500);
    n_cmp++;
    if (cpuinst.regfileinst.R[15] !== 16'd1) begin
      n_err++; $display("FAIL hailstone_r15: got %h want 0001", cpuinst.regfileinst.R[15]);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (cpuinst.regfileinst.R[i] !== m_r[i]) begin
        n_err++;
        $display("FAIL hailstone_R%0d: got %h want %h", i, cpuinst.regfileinst.R[i], m_r[i]);
      end
    end
    for (int k = 0; k < 6; k++) begin
      run(1);
      pc_now = cpuinst.r_pc;
      n_cmp++;
      if (pc_now !== 8'(m_pc) || (pc_now !== 8'd7 && pc_now !== 8'd8)) begin
        n_err++; $display("FAIL hailstone_spin: pc got %0d want %0d", pc_now, m_pc);
      end
    end
  endtask

  task automatic test_reset_mid_execute();
    hold_reset();
    clear_mem();
    setr(5, 16'h1234);
    setr(6, 16'h0001);
    put(0, 16'h5556);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (cpuinst.regfileinst.R[5] !== 16'h1234) begin
      n_err++; $display("FAIL midreset_dst: got %h want 1234", cpuinst.regfileinst.R[5]);
    end
    n_cmp++;
    if (cpuinst.r_pc !== 8'd0) begin
      n_err++; $display("FAIL midreset_pc: got %0d want 0", cpuinst.r_pc);
    end
    run(1);
    n_cmp++;
    if (cpuinst.regfileinst.R[5] !== 16'h1235) begin
      n_err++; $display("FAIL midreset_rerun: got %h want 1235", cpuinst.regfileinst.R[5]);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [7:0] lo;
    for (int it = 0; it < 8; it++) begin
      hold_reset();
      clear_mem();
      for (int i = 0; i < 16; i++)
        setr(i, ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 18)) : 16'($urandom));
      for (int a = 0; a < 32; a++) begin
        op = 4'($urandom_range(0, 15));
        lo = (op == 4'd10 || op == 4'd11) ? 8'($urandom_range(0, 31)) : 8'($urandom);
        put(a, {op, 4'($urandom), lo});
      end
      run(60);
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (cpuinst.regfileinst.R[i] !== m_r[i]) begin
          n_err++;
          $display("FAIL random_%0d_R%0d: got %h want %h", it, i,
                   cpuinst.regfileinst.R[i], m_r[i]);
        end
      end
      n_cmp++;
      if (cpuinst.r_pc !== 8'(m_pc)) begin
        n_err++; $display("FAIL random_%0d_pc: got %0d want %0d", it, cpuinst.r_pc, m_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wide_const();
    test_bounds();
    test_branch();
    test_hailstone();
    test_reset_mid_execute();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
